// File: rtl/counter_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | counter_seq_pkg                                                      |
// | Shared FSM state encoding and counter limit for counter_sequencer.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package counter_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10
  } state_t;

  localparam logic [3:0] CNT_MAX = 4'd15;

endpackage
`default_nettype wire

// File: rtl/counter_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | counter_sequencer_if                                                 |
// | Control/status bundle between a controller and counter_sequencer.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface counter_sequencer_if;
  import counter_seq_pkg::*;

  logic       start;
  logic       stop;
  logic       periodic;
  logic [3:0] preset;
  logic [3:0] Q;
  logic       busy;
  logic       done;
  state_t     state;

  modport master (
    output start, stop, periodic, preset,
    input  Q, busy, done, state
  );

  modport slave (
    input  start, stop, periodic, preset,
    output Q, busy, done, state
  );

endinterface
`default_nettype wire

// File: rtl/counter_sequencer_counter4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | counter4                                                             |
// | 4-bit counter: async clear, sync load, dual count enables, carry.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module counter4
  import counter_seq_pkg::*;
(
  input  logic       CP,
  input  logic       Cr,
  input  logic       Ld,
  input  logic       CTP,
  input  logic       CTT,
  input  logic [3:0] D,
  output logic [3:0] Q,
  output logic       Co
);

  logic [3:0] r_q;

  // Load takes priority over counting.
  always_ff @(posedge CP or posedge Cr) begin
    if (Cr) begin
      r_q <= 4'd0;
    end else if (Ld) begin
      r_q <= D;
    end else if (CTP && CTT) begin
      r_q <= r_q + 4'd1;
    end
  end

  assign Q  = r_q;
  assign Co = (r_q == CNT_MAX) && CTT;

endmodule
`default_nettype wire

// File: rtl/counter_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | counter_sequencer                                                    |
// | IDLE->LOAD->RUN sequencer driving counter4; one-shot or auto-reload. |
// | Macro COUNTER_SEQUENCER_PERIODIC_EN enables the periodic input.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module counter_sequencer
  import counter_seq_pkg::*;
(
  input logic                 CP,
  input logic                 CR,
  counter_sequencer_if.slave  bus
);

  state_t     r_state;
  state_t     w_next;
  logic       r_done;
  logic       w_done_set;
  logic       w_ld;
  logic       w_ctp;
  logic       w_ctt;
  logic       w_co;
  logic       w_periodic;
  logic [3:0] w_q;

`ifdef COUNTER_SEQUENCER_PERIODIC_EN
  assign w_periodic = bus.periodic;
`else
  logic w_unused_periodic;
  assign w_unused_periodic = bus.periodic;
  assign w_periodic        = 1'b0;
`endif

  assign w_ctt = (r_state == RUN);

  counter4 u_counter4 (
    .CP  (CP),
    .Cr  (CR),
    .Ld  (w_ld),
    .CTP (w_ctp),
    .CTT (w_ctt),
    .D   (bus.preset),
    .Q   (w_q),
    .Co  (w_co)
  );

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done_set;
    end
  end

  // Stop beats a coincident terminal count; counting is gated off at terminal
  // so a one-shot run parks at 15.
  always_comb begin
    w_next     = r_state;
    w_ld       = 1'b0;
    w_ctp      = 1'b0;
    w_done_set = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start && !bus.stop) w_next = LOAD;
      end
      LOAD: begin
        if (bus.stop) begin
          w_next = IDLE;
        end else begin
          w_ld   = 1'b1;
          w_next = RUN;
        end
      end
      RUN: begin
        if (bus.stop) begin
          w_next = IDLE;
        end else if (w_co) begin
          w_done_set = 1'b1;
          if (w_periodic) w_ld = 1'b1;
          else            w_next = IDLE;
        end else begin
          w_ctp = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign bus.Q     = w_q;
  assign bus.busy  = (r_state == LOAD) || (r_state == RUN);
  assign bus.done  = r_done;
  assign bus.state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_counter_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_counter_sequencer                                                 |
// | Table vectors, corner sequences and random run vs. reference model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_counter_sequencer;
  import counter_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  counter_sequencer_if bus();

  counter_sequencer dut (
    .CP  (clk),
    .CR  (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: run phase 0=idle 1=load 2=run, counter value, done pulse.
  int m_state;
  int m_q;
  bit m_done;

  typedef struct {
    bit         start;
    bit         stop;
    bit         periodic;
    logic [3:0] preset;
    int         q;
    int         st;
    bit         done;
  } vec_t;

  vec_t vecs[14];

  function automatic bit per_eff(bit p);
`ifdef COUNTER_SEQUENCER_PERIODIC_EN
    return p;
`else
    return 1'b0 & p;
`endif
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(string tag, int q, int st, bit d);
    chk({tag, " Q"},     int'(bus.Q),     q);
    chk({tag, " state"}, int'(bus.state), st);
    chk({tag, " busy"},  int'(bus.busy),  (st != 0) ? 1 : 0);
    chk({tag, " done"},  int'(bus.done),  int'(d));
  endtask

  task automatic drive(bit s, bit p, bit per, logic [3:0] pre);
    bus.start    = s;
    bus.stop     = p;
    bus.periodic = per;
    bus.preset   = pre;
  endtask

  task automatic model_step();
    m_done = 1'b0;
    case (m_state)
      0: if (bus.start && !bus.stop) m_state = 1;
      1: begin
        if (bus.stop) m_state = 0;
        else begin
          m_q     = int'(bus.preset);
          m_state = 2;
        end
      end
      default: begin
        if (bus.stop) m_state = 0;
        else if (m_q == 15) begin
          m_done = 1'b1;
          if (per_eff(bus.periodic)) m_q = int'(bus.preset);
          else                       m_state = 0;
        end else begin
          m_q = (m_q + 1) % 16;
        end
      end
    endcase
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_expect(string tag, int q, int st, bit d);
    tick();
    check_outputs(tag, q, st, d);
  endtask

  task automatic tick_model(string tag);
    tick();
    check_outputs(tag, m_q, m_state, m_done);
  endtask

  // Called just after a rising edge; asserts reset between edges.
  task automatic async_reset(string tag);
    #2 rst = 1'b1;
    #1;
    check_outputs(tag, 0, 0, 1'b0);
    m_state = 0;
    m_q     = 0;
    m_done  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1, 0, 0, 4'd12, 0,  1, 0};
    vecs[1]  = '{0, 0, 0, 4'd12, 12, 2, 0};
    vecs[2]  = '{0, 0, 0, 4'd12, 13, 2, 0};
    vecs[3]  = '{0, 0, 0, 4'd12, 14, 2, 0};
    vecs[4]  = '{0, 0, 0, 4'd12, 15, 2, 0};
    vecs[5]  = '{0, 0, 0, 4'd12, 15, 0, 1};
    vecs[6]  = '{0, 0, 0, 4'd12, 15, 0, 0};
    vecs[7]  = '{1, 1, 0, 4'd5,  15, 0, 0};
    vecs[8]  = '{1, 0, 0, 4'd3,  15, 1, 0};
    vecs[9]  = '{0, 1, 0, 4'd3,  15, 0, 0};
    vecs[10] = '{1, 0, 0, 4'd9,  15, 1, 0};
    vecs[11] = '{1, 0, 0, 4'd2,  2,  2, 0};
    vecs[12] = '{1, 0, 0, 4'd2,  3,  2, 0};
    vecs[13] = '{0, 1, 0, 4'd2,  3,  0, 0};

    drive(0, 0, 0, 4'd0);
    m_state = 0;
    m_q     = 0;
    m_done  = 1'b0;

    @(negedge clk);
    check_outputs("reset", 0, 0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].periodic, vecs[i].preset);
      tick();
      check_outputs($sformatf("vec%0d", i), vecs[i].q, vecs[i].st, vecs[i].done);
    end

    // Reset mid-run at Q=7, then no done after release.
    drive(1, 0, 0, 4'd4);
    tick_expect("rst_load", 3, 1, 0);
    drive(0, 0, 0, 4'd4);
    tick_expect("rst_q4", 4, 2, 0);
    tick_expect("rst_q5", 5, 2, 0);
    tick_expect("rst_q6", 6, 2, 0);
    tick_expect("rst_q7", 7, 2, 0);
    async_reset("rst_async");
    for (int i = 0; i < 3; i++) tick_expect("rst_after", 0, 0, 0);

    // Abort at Q=14.
    drive(1, 0, 0, 4'd12);
    tick_expect("ab_load", 0, 1, 0);
    drive(0, 0, 0, 4'd12);
    tick_expect("ab_q12", 12, 2, 0);
    tick_expect("ab_q13", 13, 2, 0);
    tick_expect("ab_q14", 14, 2, 0);
    drive(0, 1, 0, 4'd12);
    tick_expect("abort14", 14, 0, 0);
    drive(0, 0, 0, 4'd12);
    tick_expect("abort14_hold", 14, 0, 0);

    // Stop coincident with terminal count.
    drive(1, 0, 0, 4'd14);
    tick_expect("st_load", 14, 1, 0);
    drive(0, 0, 0, 4'd14);
    tick_expect("st_q14", 14, 2, 0);
    tick_expect("st_q15", 15, 2, 0);
    drive(0, 1, 0, 4'd14);
    tick_expect("stop15", 15, 0, 0);
    drive(0, 0, 0, 4'd14);
    tick_expect("stop15_hold", 15, 0, 0);

`ifdef COUNTER_SEQUENCER_PERIODIC_EN
    drive(1, 0, 1, 4'd13);
    tick_expect("per_load", 15, 1, 0);
    drive(0, 0, 1, 4'd13);
    for (int k = 0; k < 2; k++) begin
      tick_expect("per_q13", 13, 2, (k != 0));
      tick_expect("per_q14", 14, 2, 0);
      tick_expect("per_q15", 15, 2, 0);
    end
    tick_expect("per_q13", 13, 2, 1);
    drive(0, 1, 1, 4'd13);
    tick_expect("per_stop", 13, 0, 0);

    drive(1, 0, 1, 4'd15);
    tick_expect("p15_load", 13, 1, 0);
    drive(0, 0, 1, 4'd15);
    tick_expect("p15_first", 15, 2, 0);
    for (int k = 0; k < 3; k++) tick_expect("p15_run", 15, 2, 1);
    drive(0, 1, 1, 4'd15);
    tick_expect("p15_stop", 15, 0, 0);
`else
    drive(1, 0, 1, 4'd12);
    tick_expect("off_load", 15, 1, 0);
    drive(0, 0, 1, 4'd12);
    tick_expect("off_q12", 12, 2, 0);
    tick_expect("off_q13", 13, 2, 0);
    tick_expect("off_q14", 14, 2, 0);
    tick_expect("off_q15", 15, 2, 0);
    tick_expect("off_term", 15, 0, 1);
    tick_expect("off_idle", 15, 0, 0);
`endif

    async_reset("rand_rst");
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 63) == 0) begin
        async_reset("rand_async");
      end
      drive($urandom_range(0, 3) == 0,
            $urandom_range(0, 11) == 0,
            $urandom_range(0, 1) == 1,
            ($urandom_range(0, 1) == 1) ? 4'($urandom_range(12, 15))
                                        : 4'($urandom_range(0, 15)));
      tick_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 SHALL have port CP, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port CR, input, 1 bit: one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: level-sampled request to begin a count run.
REQ-004 SHALL have port stop, input, 1 bit: level-sampled abort of the current run.
REQ-005 SHALL have port periodic, input, 1 bit: 1 selects auto-reload, 0 selects one-shot.
REQ-006 SHALL have port preset, input, 4 bits: start value loaded into the counter.
REQ-007 SHALL have port Q, output, 4 bits: current counter value.
REQ-008 SHALL have port busy, output, 1 bit: 1 while state is LOAD or RUN.
REQ-009 SHALL have port done, output, 1 bit: registered one-cycle terminal pulse.
REQ-010 SHALL have port state, output, 2 bits: FSM encoding IDLE=00, LOAD=01, RUN=10.

Function
REQ-011 SHALL implement FSM IDLE -> LOAD -> RUN, driving the counter sub-module's load and count-enable inputs.
REQ-012 SHALL move IDLE -> LOAD on an edge where start=1; in IDLE the counter holds Q.
REQ-013 SHALL, in LOAD, assert sync load so that at the next edge Q=preset (sampled that cycle) and state=RUN.
REQ-014 SHALL, in RUN with stop=0, increment Q by 1 per edge, modulo 16.
REQ-015 SHALL treat RUN with Q=15 as terminal (counter carry Co=1); at that edge done=1 for exactly one cycle.
REQ-016 SHALL, at terminal edge with periodic=1, sync-load preset (Q: 15 -> preset) and stay in RUN: period 16-preset cycles, no dead cycle.
REQ-017 SHALL, at terminal edge with periodic=0, go to IDLE with Q held at 15.
REQ-018 SHALL, on stop=1 in LOAD or RUN, go to IDLE at that edge, hold Q, and not pulse done; stop wins over simultaneous terminal.
REQ-019 SHALL ignore start while busy=1; start and stop both 1 in IDLE: stay IDLE.
REQ-020 SHALL handle preset=15: first RUN cycle is terminal, done follows one cycle later (period 1 when periodic).
REQ-021 SHALL sample periodic only at the terminal edge.

Reset
REQ-022 SHALL, while CR=1, force state=IDLE, Q=0, done=0, busy=0 immediately, independent of CP.
REQ-023 SHALL, on CR asserted mid-run, abort without done pulse; after release, wait in IDLE for start.

Configuration
REQ-024 SHALL honour macro COUNTER_SEQUENCER_PERIODIC_EN: defined -> periodic input functional per REQ-016.
REQ-025 SHALL, without COUNTER_SEQUENCER_PERIODIC_EN, keep the periodic port but ignore it; every run is one-shot (REQ-017).

Structure
REQ-026 SHALL place the FSM state typedef/encodings (IDLE, LOAD, RUN) and constant CNT_MAX=15 in shared package counter_seq_pkg.
REQ-027 SHALL instantiate one sub-module counter4: 4-bit counter with async clear, sync load (Ld), enables CTP/CTT, carry Co=(Q==15)&CTT.

Verification
REQ-028 SHALL cover reset: CR=1 mid-RUN at Q=7 -> Q=0, state=00, done=0 immediately; no done after release.
REQ-029 SHALL cover one-shot: preset=12, periodic=0, start pulse -> LOAD, Q=12,13,14,15 on successive edges, done one cycle, then IDLE with Q=15.
REQ-030 SHALL cover periodic: preset=13, periodic=1 -> Q cycles 13,14,15,13,...; done every 3 cycles, busy stays 1.
REQ-031 SHALL cover abort: stop=1 when Q=14 in RUN -> IDLE, Q holds 14, no done; stop coincident with Q=15 -> no done.
REQ-032 SHALL cover preset=15, periodic=1 -> Q constant 15, done high every cycle after first RUN cycle.
REQ-033 SHALL cover macro off: periodic=1, preset=12 -> behaves as REQ-029 one-shot.
